mean3x3_window_ctrl: RTL and testbench

- Streaming controller that sequences a raster pixel stream into 3x3 windows for the combinational 3x3 averaging stage (nine 8-bit taps in, one 8-bit mean out) of the dehazing pipeline.
- Owns two line buffers, the 3x3 window shift registers, row/column counters, the frame state machine, and valid/ready handshakes on both sides.
- Emits interior windows only: (IMG_W-2)*(IMG_H-2) windows per frame.

---
 rtl/mean3x3_window_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mean3x3_window_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean3x3_window_ctrl.sv
// rtl/mean3x3_window_ctrl.sv - raster-to-3x3 window sequencer for the mean filter stage
//
// Purpose: accepts a raster pixel stream, keeps the two previous rows in line
// buffers and a 3x3 shift window, and presents each interior 3x3 window (with its
// centre coordinate) to the combinational averager through a valid/ready handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle frame start pulse, honoured only when idle
//   in_valid/in_ready upstream pixel handshake; in_pixel carries the raster pixel
//   win_valid/ready   downstream window handshake
//   win_taps          nine taps, in1 (top-left) in [7:0] .. in9 (bottom-right) in [71:64]
//   win_row/win_col   centre coordinate of the presented window
//   busy              high whenever a frame is in progress
//   frame_done        one-cycle pulse after the last window has been taken

module mean3x3_window_ctrl #(
   parameter int IMG_W   = 512,
   parameter int IMG_H   = 512,
   parameter int COORD_W = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_pixel,
   output logic               win_valid,
   input  logic               win_ready,
   output logic [71:0]        win_taps,
   output logic [COORD_W-1:0] win_row,
   output logic [COORD_W-1:0] win_col,
   output logic               busy,
   output logic               frame_done
);

   localparam int IDX_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
   localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state;

   logic [COORD_W-1:0] row;
   logic [COORD_W-1:0] col;
   logic [IDX_W-1:0]   col_idx;

   // lb1 holds row r-1, lb0 holds row r-2 at the column being written.
   logic [7:0] lb0 [0:IMG_W-1];
   logic [7:0] lb1 [0:IMG_W-1];

   // Window columns, each packed {bottom, middle, top}.
   logic [23:0] col_l;
   logic [23:0] col_m;
   logic [23:0] col_n;

   logic        accept;
   logic        last_col;
   logic        qualifies;
   logic [71:0] taps_next;

   assign col_idx  = col[IDX_W-1:0];
   assign in_ready = ((state == S_FILL) || (state == S_RUN)) && (!win_valid || win_ready);
   assign accept   = in_valid && in_ready;
   assign last_col = (col == LAST_COL);

   // Window centre is (row-1, col-1), so only row>=2 and col>=2 give an interior window.
   assign qualifies = accept && (row >= TWO) && (col >= TWO);

   assign col_n = {in_pixel, lb1[col_idx], lb0[col_idx]};

   // Row-major tap order: top row in1..in3, middle in4..in6, bottom in7..in9.
   assign taps_next = {col_n[23:16], col_m[23:16], col_l[23:16],
                       col_n[15:8],  col_m[15:8],  col_l[15:8],
                       col_n[7:0],   col_m[7:0],   col_l[7:0]};

   // Line buffers carry no reset; their contents are only read after this frame wrote them.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0[col_idx] <= lb1[col_idx];
         lb1[col_idx] <= in_pixel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         row        <= '0;
         col        <= '0;
         col_l      <= '0;
         col_m      <= '0;
         win_valid  <= 1'b0;
         win_taps   <= '0;
         win_row    <= '0;
         win_col    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         // Accept is gated on the window slot being free or draining this cycle,
         // so a qualifying accept never overwrites an untaken window.
         if (qualifies) begin
            win_valid <= 1'b1;
            win_taps  <= taps_next;
            win_row   <= row - ONE;
            win_col   <= col - ONE;
         end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
         end

         // Stale columns from the previous row are shifted out before col reaches 2.
         if (accept) begin
            col_l <= col_m;
            col_m <= col_n;
            if (last_col) begin
               col <= '0;
               row <= row + ONE;
            end else begin
               col <= col + ONE;
            end
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_FILL;
                  busy  <= 1'b1;
                  row   <= '0;
                  col   <= '0;
                  col_l <= '0;
                  col_m <= '0;
               end
            end
            S_FILL: begin
               if (accept && last_col && (row == ONE)) begin
                  state <= (IMG_H == 2) ? S_DRAIN : S_RUN;
               end
            end
            S_RUN: begin
               if (accept && last_col && (row == LAST_ROW)) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (win_valid && win_ready) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mean3x3_window_ctrl.sv
// tb/tb_mean3x3_window_ctrl.sv - randomized self-checking bench for mean3x3_window_ctrl

module tb_mean3x3_window_ctrl;

   localparam int W    = 5;
   localparam int H    = 4;
   localparam int CW   = 10;
   localparam int NPIX = W * H;
   localparam int NWIN = (W - 2) * (H - 2);

   logic          clk;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_pixel;
   logic          win_valid;
   logic          win_ready;
   logic [71:0]   win_taps;
   logic [CW-1:0] win_row;
   logic [CW-1:0] win_col;
   logic          busy;
   logic          frame_done;

   mean3x3_window_ctrl #(.IMG_W(W), .IMG_H(H), .COORD_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_pixel   (in_pixel),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_taps   (win_taps),
      .win_row    (win_row),
      .win_col    (win_col),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [71:0] taps;
      int          r;
      int          c;
   } win_t;

   logic [7:0] img [NPIX];
   win_t       exp_q[$];

   // Reference: every interior pixel (r,c) is the centre of one window, in raster order.
   function automatic void build_model();
      exp_q.delete();
      for (int r = 1; r <= H - 2; r++) begin
         for (int c = 1; c <= W - 2; c++) begin
            win_t w;
            w.taps = '0;
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  w.taps[8*(dr*3+dc) +: 8] = img[(r-1+dr)*W + (c-1+dc)];
            w.r = r;
            w.c = c;
            exp_q.push_back(w);
         end
      end
   endfunction

   function automatic int mean9(input logic [71:0] t);
      int s = 0;
      for (int k = 0; k < 9; k++) s += int'(t[8*k +: 8]);
      return s / 9;
   endfunction

   task automatic fill_img(input int mode);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            case (mode)
               0:       img[r*W+c] = 8'd100;
               1:       img[r*W+c] = 8'(r*W + c);
               default: img[r*W+c] = 8'($urandom);
            endcase
   endtask

   // Called at a negedge; start is raised immediately.
   task automatic run_frame(input int vpct, input int rpct, input bit stall_en,
                            input bit poke_start,
                            output logic [71:0] first_taps, output logic [71:0] last_taps);
      int          idx = 0;
      int          got = 0;
      int          last_hs = -100;
      int          stall_cnt = 0;
      int          cyc = 0;
      bit          stall_done = 0;
      bit          poked = 0;
      bit          prev_hold = 0;
      bit          finished = 0;
      logic [71:0] held_taps = '0;
      logic [2*CW-1:0] held_coord = '0;
      first_taps = '0;
      last_taps  = '0;
      build_model();
      start    = 1'b1;
      in_valid = 1'b0;
      win_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      while (!finished && cyc < 2000) begin
         if (prev_hold) begin
            check("hold_valid", win_valid, 1);
            check("hold_taps", win_taps, held_taps);
            check("hold_coord", {win_row, win_col}, held_coord);
         end
         if (stall_en && !stall_done && win_valid) begin
            stall_cnt  = 3;
            stall_done = 1;
         end
         if (stall_cnt > 0) begin
            win_ready = 1'b0;
            stall_cnt--;
         end else begin
            win_ready = ($urandom_range(99) < rpct);
         end
         in_valid = (idx < NPIX) && ($urandom_range(99) < vpct);
         in_pixel = (idx < NPIX) ? img[idx] : 8'($urandom);
         start = 1'b0;
         if (poke_start && !poked && idx == 2*W + 1) begin
            start = 1'b1;
            poked = 1;
         end
         #1;
         check("in_ready", in_ready, (idx < NPIX) && (!win_valid || win_ready));
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_window", 1, 0);
            end else begin
               win_t w = exp_q.pop_front();
               check("taps", win_taps, w.taps);
               check("win_row", win_row, w.r);
               check("win_col", win_col, w.c);
               if (got == 0) first_taps = win_taps;
               last_taps = win_taps;
               got++;
               last_hs = cyc;
            end
         end
         prev_hold  = win_valid && !win_ready;
         held_taps  = win_taps;
         held_coord = {win_row, win_col};
         if (frame_done) begin
            check("done_timing", cyc, last_hs + 1);
            check("window_count", got, NWIN);
            finished = 1;
         end
         if (in_valid && in_ready) idx++;
         cyc++;
         @(negedge clk);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (!finished) check("frame_timeout", 0, 1);
      check("done_one_cycle", frame_done, 0);
      check("idle_busy", busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_win_valid"}, win_valid, 0);
      check({tag, "_win_taps"}, win_taps, 0);
      check({tag, "_win_row"}, win_row, 0);
      check({tag, "_win_col"}, win_col, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   // Feeds gap-free until row 2 col 2 is accepted, then resets asynchronously.
   task automatic run_abort();
      int idx = 0;
      int cyc = 0;
      fill_img(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (idx < 2*W + 3 && cyc < 200) begin
         win_ready = 1'b1;
         in_valid  = 1'b1;
         in_pixel  = img[idx];
         #1;
         if (in_valid && in_ready) idx++;
         cyc++;
         @(negedge clk);
      end
      if (idx < 2*W + 3) check("abort_timeout", 0, 1);
      #1;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check_all_zero("after_reset");
      @(negedge clk);
   endtask

   logic [71:0] ft;
   logic [71:0] lt;

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_pixel  = '0;
      win_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      start = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      check("start_idle_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      fill_img(0);
      run_frame(100, 100, 0, 0, ft, lt);

      fill_img(1);
      run_frame(100, 100, 0, 0, ft, lt);
      check("ramp_first_mean", mean9(ft), 6);
      check("ramp_last_mean", mean9(lt), 13);

      run_frame(100, 100, 1, 0, ft, lt);
      run_frame(50, 100, 0, 0, ft, lt);
      check("gappy_first_mean", mean9(ft), 6);

      fill_img(2);
      run_frame(60, 60, 0, 0, ft, lt);

      run_abort();

      fill_img(2);
      run_frame(100, 100, 0, 0, ft, lt);
      fill_img(2);
      run_frame(100, 100, 0, 1, ft, lt);
      for (int f = 0; f < 4; f++) begin
         fill_img(2);
         run_frame(70, 70, f[0], f[1], ft, lt);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
